// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU ops, opcode/funct fields,
// datapath selects, FSM states, instruction classes and the per-state control word.
package mips_ctrl_pkg;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_SLT = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b011;
  localparam logic [2:0] ALUOP_LUI = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  typedef enum logic [9:0] {
    S_FETCH  = 10'b00_0000_0001,
    S_DECODE = 10'b00_0000_0010,
    S_EXE    = 10'b00_0000_0100,
    S_ALUWB  = 10'b00_0000_1000,
    S_MEMADR = 10'b00_0001_0000,
    S_MEMRD  = 10'b00_0010_0000,
    S_MEMWB  = 10'b00_0100_0000,
    S_MEMWR  = 10'b00_1000_0000,
    S_BRANCH = 10'b01_0000_0000,
    S_JUMP   = 10'b10_0000_0000
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_RTYPE, CLS_ORI, CLS_LUI, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J
  } cls_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic [1:0] alu_srcb;
    logic       ext_op;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       rf_we;
    logic       reg_dst;
    logic       mem2reg;
    logic       dm_we;
  } ctrl_t;

  // ALUWB repeats the EXE ALU controls so the oflow flag stays valid for the write decision.
  function automatic ctrl_t state_ctrl(state_e s, cls_e c, logic [2:0] alu, logic ext);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.ir_we    = 1'b1;
        o.pc_we    = 1'b1;
        o.pc_src   = PCSRC_SEQ;
        o.aluop    = ALUOP_ADD;
        o.alu_srcb = SRCB_FOUR;
      end
      S_EXE, S_ALUWB: begin
        o.aluop    = alu;
        o.alu_srcb = (c == CLS_RTYPE) ? SRCB_REG : SRCB_IMM;
        o.ext_op   = ext;
        if (s == S_ALUWB) begin
          o.rf_we   = 1'b1;
          o.reg_dst = (c == CLS_RTYPE);
        end
      end
      S_MEMADR: begin
        o.aluop    = ALUOP_ADD;
        o.alu_srcb = SRCB_IMM;
        o.ext_op   = 1'b1;
      end
      S_MEMWB: begin
        o.rf_we   = 1'b1;
        o.mem2reg = 1'b1;
      end
      S_MEMWR:  o.dm_we = 1'b1;
      S_BRANCH: begin
        o.aluop    = ALUOP_SUB;
        o.alu_srcb = SRCB_REG;
        o.pc_src   = PCSRC_BR;
      end
      S_JUMP: begin
        o.pc_we  = 1'b1;
        o.pc_src = PCSRC_JMP;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: {op,funct} -> class, EXE-stage ALU op, extend mode.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [2:0] aluop_o,
  output logic       ext_op_o,
  output logic       illegal_o
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    cls_o    = CLS_NONE;
    aluop_o  = ALUOP_ADD;
    ext_op_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_ADDU: begin cls_o = CLS_RTYPE; aluop_o = ALUOP_ADD; end
          FUNCT_SUBU: begin cls_o = CLS_RTYPE; aluop_o = ALUOP_SUB; end
          FUNCT_SLT:  begin cls_o = CLS_RTYPE; aluop_o = ALUOP_SLT; end
          default: ;
        endcase
      end
      OP_ORI:  begin cls_o = CLS_ORI;  aluop_o = ALUOP_OR;  end
      OP_LUI:  begin cls_o = CLS_LUI;  aluop_o = ALUOP_LUI; end
      OP_ADDI: begin cls_o = CLS_ADDI; aluop_o = ALUOP_ADD; ext_op_o = 1'b1; end
      OP_LW:   begin cls_o = CLS_LW;   aluop_o = ALUOP_ADD; ext_op_o = 1'b1; end
      OP_SW:   begin cls_o = CLS_SW;   aluop_o = ALUOP_ADD; ext_op_o = 1'b1; end
      OP_BEQ:  begin cls_o = CLS_BEQ;  aluop_o = ALUOP_SUB; end
      OP_J:    cls_o = CLS_J;
      default: ;
    endcase
    illegal_o = (cls_o == CLS_NONE);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: one-hot state, registered Moore control word, with the
// ALU flags (zero, oflow) gating the branch PC write and the addi register write.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       oflow,
  output logic [2:0] aluop,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       rf_we,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       dm_we,
  output logic       illegal
);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic [2:0] alu_q, alu_d, dec_aluop;
  logic       ext_q, ext_d, dec_ext, dec_illegal;
  ctrl_t      ctrl_q;

  mc_ctrl_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (dec_cls),
    .aluop_o   (dec_aluop),
    .ext_op_o  (dec_ext),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = S_FETCH;
    cls_d   = cls_q;
    alu_d   = alu_q;
    ext_d   = ext_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        alu_d = dec_aluop;
        ext_d = dec_ext;
        case (dec_cls)
          CLS_BEQ:        state_d = S_BRANCH;
          CLS_J:          state_d = S_JUMP;
          CLS_LW, CLS_SW: state_d = S_MEMADR;
          CLS_NONE:       state_d = S_FETCH;
          default:        state_d = S_EXE;
        endcase
      end
      S_EXE:    state_d = S_ALUWB;
      S_MEMADR: state_d = (cls_q == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_NONE;
      alu_q   <= ALUOP_ADD;
      ext_q   <= 1'b0;
      ctrl_q  <= state_ctrl(S_FETCH, CLS_NONE, ALUOP_ADD, 1'b0);
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      ext_q   <= ext_d;
      ctrl_q  <= state_ctrl(state_d, cls_d, alu_d, ext_d);
    end
  end

  // While rst is high every enable is forced off, including writes already queued this cycle.
  assign aluop    = rst ? ALUOP_ADD    : ctrl_q.aluop;
  assign alu_srcb = rst ? SRCB_REG     : ctrl_q.alu_srcb;
  assign pc_src   = rst ? RESET_PC_SEL : ctrl_q.pc_src;
  assign ext_op   = !rst && ctrl_q.ext_op;
  assign ir_we    = !rst && ctrl_q.ir_we;
  assign reg_dst  = !rst && ctrl_q.reg_dst;
  assign mem2reg  = !rst && ctrl_q.mem2reg;
  assign dm_we    = !rst && ctrl_q.dm_we;
  assign pc_we    = !rst && (ctrl_q.pc_we || (state_q == S_BRANCH && zero));
  assign rf_we    = !rst && ctrl_q.rf_we &&
                    !(state_q == S_ALUWB && cls_q == CLS_ADDI && oflow);
  assign illegal  = !rst && (state_q == S_DECODE) && dec_illegal;

endmodule
